// File: rtl/sha256_pad_block.sv
// Single-block SHA-256 message padder: message, a '1' bit, zero fill, and a 64-bit length.
// The datapath is combinational from the inputs, and the result is registered on in_valid.
module sha256_pad_block #(
   parameter int MAX_MSG_BITS = 447
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    in_valid,
   input  logic [MAX_MSG_BITS-1:0] msg_data,
   input  logic [8:0]              msg_len,
   output logic [511:0]            padding,
   output logic                    out_valid,
   output logic                    len_err
);

   localparam int            FILL_BITS = 512 - MAX_MSG_BITS;
   localparam logic [8:0]    MAX_LEN   = 9'(MAX_MSG_BITS);
   localparam logic [511:0]  ALL_ONES  = '1;
   localparam logic [511:0]  TOP_BIT   = {1'b1, 511'b0};

   logic         w_len_ok;
   logic [511:0] w_msg_aligned;
   logic [511:0] w_keep_mask;
   logic [511:0] w_padding;

   logic [511:0] r_padding;
   logic         r_out_valid;
   logic         r_len_err;

   assign w_len_ok      = (msg_len <= MAX_LEN);
   assign w_msg_aligned = {msg_data, {FILL_BITS{1'b0}}};
   // Top L bits set; this masks off the don't-care data below the message.
   assign w_keep_mask   = ~(ALL_ONES >> msg_len);

   always_comb begin
      // NOTE: a default on entry keeps every path assigned, so no latch is inferred.
      w_padding = '0;
      if (w_len_ok) begin
         w_padding = (w_msg_aligned & w_keep_mask)
                   | (TOP_BIT >> msg_len)
                   | {448'b0, 55'b0, msg_len};
      end
   end

   // NOTE: sequential state uses non-blocking assignments, and reset is synchronous (sampled on clk).
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_padding   <= '0;
         r_out_valid <= 1'b0;
         r_len_err   <= 1'b0;
      end else begin
         r_out_valid <= in_valid;
         if (in_valid) begin
            r_padding <= w_padding;
            r_len_err <= ~w_len_ok;
         end
      end
   end

   assign padding   = r_padding;
   assign out_valid = r_out_valid;
   assign len_err   = r_len_err;

endmodule

// File: tb/tb_sha256_pad_block.sv
// Scoreboard bench for sha256_pad_block: known-answer vectors plus randomized traffic checked
// against a bit-level reference model.
module tb_sha256_pad_block;

   localparam int MAXB = 447;

   logic            clk = 1'b0;
   logic            reset_n = 1'b0;
   logic            in_valid = 1'b0;
   logic [MAXB-1:0] msg_data = '0;
   logic [8:0]      msg_len = '0;
   logic [511:0]    padding;
   logic            out_valid;
   logic            len_err;

   sha256_pad_block #(.MAX_MSG_BITS(MAXB)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .msg_data  (msg_data),
      .msg_len   (msg_len),
      .padding   (padding),
      .out_valid (out_valid),
      .len_err   (len_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int           due;
      logic         vld;
      logic [511:0] pad;
      logic         err;
   } exp_t;

   exp_t         sb[$];
   int           cyc = 0;
   int           checks = 0;
   int           errors = 0;
   bit           mon_en = 1'b0;
   logic [511:0] last_pad = '0;
   logic         last_err = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   // Reference model: walks the block bit by bit from the padding rules.
   function automatic exp_t ref_model(input logic [MAXB-1:0] d, input int len);
      exp_t e;
      e.due = 0;
      e.vld = 1'b1;
      e.pad = '0;
      e.err = 1'b0;
      if (len > MAXB) begin
         e.err = 1'b1;
      end else begin
         for (int i = 0; i < len; i++) e.pad[511-i] = d[MAXB-1-i];
         e.pad[511-len] = 1'b1;
         for (int b = 0; b < 64; b++) e.pad[b] = ((len >> b) & 1) != 0;
      end
      return e;
   endfunction

   function automatic exp_t mk(input logic [511:0] p, input logic err, input logic vld);
      exp_t e;
      e.due = 0;
      e.vld = vld;
      e.pad = p;
      e.err = err;
      return e;
   endfunction

   task automatic step(input logic v, input logic [MAXB-1:0] d, input int len, input logic rn,
                       input bit has_exp, input exp_t e);
      exp_t q;
      @(posedge clk);
      #1;
      in_valid = v;
      msg_data = d;
      msg_len  = 9'(len);
      reset_n  = rn;
      if (has_exp) begin
         q     = e;
         q.due = cyc + 1;
         sb.push_back(q);
      end
   endtask

   task automatic idle();
      step(1'b0, msg_data, int'(msg_len), 1'b1, 1'b0, mk('0, 1'b0, 1'b0));
   endtask

   function automatic logic [MAXB-1:0] rand_data();
      logic [479:0] t;
      for (int i = 0; i < 15; i++) t[i*32 +: 32] = $urandom;
      return t[MAXB-1:0];
   endfunction

   // Monitor: pops an expectation when one is due, otherwise requires idle, holding outputs.
   always @(negedge clk) begin
      exp_t e;
      if (mon_en) begin
         if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            check("out_valid", {511'b0, out_valid}, {511'b0, e.vld});
            check("padding", padding, e.pad);
            check("len_err", {511'b0, len_err}, {511'b0, e.err});
            last_pad = e.pad;
            last_err = e.err;
         end else begin
            check("idle_out_valid", {511'b0, out_valid}, 512'b0);
            check("hold_padding", padding, last_pad);
            check("hold_len_err", {511'b0, len_err}, {511'b0, last_err});
         end
      end
   end

   initial begin
      logic [MAXB-1:0] d;
      int              len;
      int              sel;

      // Reset together with in_valid: the capture is discarded.
      step(1'b1, rand_data(), 24, 1'b0, 1'b1, mk('0, 1'b0, 1'b0));
      mon_en = 1'b1;
      idle();

      // "abc" and "cde" with garbage below the message.
      d = '0;
      d[MAXB-1 -: 24] = 24'h616263;
      step(1'b1, d, 24, 1'b1, 1'b1, mk({32'h61626380, 416'b0, 64'h18}, 1'b0, 1'b1));
      idle();
      d = rand_data();
      d[MAXB-1 -: 24] = 24'h636465;
      step(1'b1, d, 24, 1'b1, 1'b1, mk({32'h63646580, 416'b0, 64'h18}, 1'b0, 1'b1));
      idle();

      // Length boundaries.
      step(1'b1, rand_data(), 0, 1'b1, 1'b1, mk({1'b1, 511'b0}, 1'b0, 1'b1));
      step(1'b1, '1, 447, 1'b1, 1'b1, mk({{448{1'b1}}, 64'h1BF}, 1'b0, 1'b1));
      idle();
      step(1'b1, '1, 448, 1'b1, 1'b1, mk('0, 1'b1, 1'b1));
      idle();
      d = rand_data();
      d[MAXB-1 -: 8] = 8'hFF;
      step(1'b1, d, 8, 1'b1, 1'b1, mk({32'hFF800000, 416'b0, 64'h8}, 1'b0, 1'b1));
      idle();
      step(1'b1, rand_data(), 511, 1'b1, 1'b1, mk('0, 1'b1, 1'b1));
      idle();

      // Back-to-back captures.
      for (int i = 0; i < 3; i++) begin
         d   = rand_data();
         len = 8 * (i + 1) + 5;
         step(1'b1, d, len, 1'b1, 1'b1, ref_model(d, len));
      end
      idle();
      idle();

      // Reset while holding data, then a normal capture right after release.
      step(1'b1, rand_data(), 100, 1'b0, 1'b1, mk('0, 1'b0, 1'b0));
      d = rand_data();
      step(1'b1, d, 100, 1'b1, 1'b1, ref_model(d, 100));
      idle();

      // Randomized traffic, including occasional resets.
      for (int n = 0; n < 300; n++) begin
         d   = rand_data();
         sel = $urandom_range(0, 9);
         case (sel)
            0:       len = 0;
            1:       len = 447;
            2:       len = $urandom_range(448, 511);
            default: len = $urandom_range(1, 446);
         endcase
         if ($urandom_range(0, 39) == 0)
            step(1'b1, d, len, 1'b0, 1'b1, mk('0, 1'b0, 1'b0));
         else if ($urandom_range(0, 9) < 7)
            step(1'b1, d, len, 1'b1, 1'b1, ref_model(d, len));
         else
            step(1'b0, d, len, 1'b1, 1'b0, mk('0, 1'b0, 1'b0));
      end

      for (int i = 0; i < 4; i++) idle();
      @(posedge clk);
      #1;
      check("scoreboard_drained", 512'(sb.size()), 512'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
